// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scan-out fetch > clear sweep > round-robin writers.
// Scan read data valid one cycle after request; writes land at the granting edge, losers hold req.
module vram_arbiter #(
    parameter int                ADDR_W      = 15,
    parameter int                DATA_W      = 12,
    parameter int                DEPTH       = 19200,
    parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic              scan_valid,

    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,

    input  logic              wr0_req,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_gnt,

    input  logic              wr1_req,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_gnt,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] caddr_q, caddr_d;
    logic              last_q, last_d;
    logic              scan_valid_q, scan_valid_d;
    logic              clear_done_q, clear_done_d;
    logic              pick1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            caddr_q      <= '0;
            last_q       <= 1'b1;
            scan_valid_q <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            caddr_q      <= caddr_d;
            last_q       <= last_d;
            scan_valid_q <= scan_valid_d;
            clear_done_q <= clear_done_d;
        end
    end

    // On a tie the writer that was not served last wins; a lone requester always wins.
    assign pick1 = wr1_req && (!wr0_req || !last_q);

    always_comb begin
        state_d      = state_q;
        caddr_d      = caddr_q;
        last_d       = last_q;
        scan_valid_d = scan_req;
        clear_done_d = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        wr0_gnt      = 1'b0;
        wr1_gnt      = 1'b0;

        if (state_q == IDLE && clear_start) begin
            state_d = CLEAR;
            caddr_d = '0;
        end

        if (reset) begin
            // Keep the RAM port quiet while reset is held, even with writers pending.
            scan_valid_d = 1'b0;
        end else if (scan_req) begin
            mem_addr = scan_addr;
        end else if (state_q == CLEAR) begin
            mem_addr  = caddr_q;
            mem_wdata = CLEAR_COLOR;
            mem_we    = 1'b1;
            if (caddr_q == LAST_ADDR) begin
                state_d      = IDLE;
                caddr_d      = '0;
                clear_done_d = 1'b1;
            end else begin
                caddr_d = caddr_q + 1'b1;
            end
        end else if (wr0_req || wr1_req) begin
            mem_we = 1'b1;
            last_d = pick1;
            if (pick1) begin
                mem_addr  = wr1_addr;
                mem_wdata = wr1_data;
                wr1_gnt   = 1'b1;
            end else begin
                mem_addr  = wr0_addr;
                mem_wdata = wr0_data;
                wr0_gnt   = 1'b1;
            end
        end
    end

    assign clear_busy = (state_q == CLEAR);
    assign clear_done = clear_done_q;
    assign scan_valid = scan_valid_q;
    assign scan_data  = mem_rdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a small synchronous-read RAM model attached.
module tb_vram_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 12;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          scan_req = 1'b0;
    logic [AW-1:0] scan_addr = '0;
    logic [DW-1:0] scan_data;
    logic          scan_valid;
    logic          clear_start = 1'b0;
    logic          clear_busy, clear_done;
    logic          wr0_req = 1'b0, wr1_req = 1'b0;
    logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
    logic [DW-1:0] wr0_data = '0, wr1_data = '0;
    logic          wr0_gnt, wr1_gnt;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    vram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP), .CLEAR_COLOR(12'h000)
    ) dut (
        .clk(clk), .reset(reset),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    task automatic idle_inputs();
        scan_req = 1'b0; clear_start = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", clear_busy); end
        checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL reset_scan_valid got=%b exp=0", scan_valid); end
        checks++; if (clear_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", clear_done); end
        checks++; if ({mem_we, wr0_gnt, wr1_gnt} !== 3'b000) begin failures++; $display("FAIL reset_port got=%b exp=000", {mem_we, wr0_gnt, wr1_gnt}); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_scan();
        @(negedge clk); wr0_req = 1'b1; wr0_addr = 8'd5; wr0_data = 12'hABC; #1;
        checks++; if (wr0_gnt !== 1'b1 || mem_addr !== 8'd5) begin failures++; $display("FAIL preload5 gnt=%b addr=%0d exp gnt=1 addr=5", wr0_gnt, mem_addr); end
        @(negedge clk); wr0_addr = 8'd6; wr0_data = 12'h123; #1;
        checks++; if (wr0_gnt !== 1'b1 || mem_wdata !== 12'h123) begin failures++; $display("FAIL preload6 gnt=%b data=%h exp gnt=1 data=123", wr0_gnt, mem_wdata); end
        @(negedge clk); wr0_req = 1'b0; scan_req = 1'b1; scan_addr = 8'd5; #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'd5) begin failures++; $display("FAIL scan_port5 we=%b addr=%0d exp we=0 addr=5", mem_we, mem_addr); end
        @(negedge clk); scan_addr = 8'd6; #1;
        checks++; if (scan_valid !== 1'b1 || scan_data !== 12'hABC || mem_we !== 1'b0) begin failures++; $display("FAIL scan_rd5 valid=%b data=%h we=%b exp 1/abc/0", scan_valid, scan_data, mem_we); end
        @(negedge clk); scan_req = 1'b0; #1;
        checks++; if (scan_valid !== 1'b1 || scan_data !== 12'h123) begin failures++; $display("FAIL scan_rd6 valid=%b data=%h exp 1/123", scan_valid, scan_data); end
        @(negedge clk); #1;
        checks++; if (scan_valid !== 1'b0) begin failures++; $display("FAIL scan_valid_drop got=%b exp=0", scan_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        int bad;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        bad = 0;
        wr0_addr = 8'd20; wr0_data = 12'h111; wr1_addr = 8'd21; wr1_data = 12'h222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); wr0_req = 1'b1; wr1_req = 1'b1; #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if ({wr1_gnt, wr0_gnt} !== exp_g || mem_we !== 1'b1) begin
                failures++; $display("FAIL rr_cycle%0d gnt=%b we=%b exp gnt=%b we=1", i, {wr1_gnt, wr0_gnt}, mem_we, exp_g);
            end
            if (wr0_gnt && wr1_gnt) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL rr_double_grant got=%0d exp=0", bad); end
        @(negedge clk); idle_inputs(); #1;
        checks++; if (mem[20] !== 12'h111 || mem[21] !== 12'h222) begin failures++; $display("FAIL rr_mem got=%h/%h exp=111/222", mem[20], mem[21]); end
    endtask

    task automatic test_scan_blocks_writer();
        wr0_addr = 8'd10; wr0_data = 12'h7F0; scan_addr = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); wr0_req = 1'b1; scan_req = 1'b1; #1;
            checks++;
            if (wr0_gnt !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL blk_cycle%0d gnt=%b we=%b exp 0/0", i, wr0_gnt, mem_we); end
        end
        @(negedge clk); scan_req = 1'b0; #1;
        checks++; if (wr0_gnt !== 1'b1 || mem_addr !== 8'd10 || mem_wdata !== 12'h7F0) begin failures++; $display("FAIL blk_release gnt=%b addr=%0d data=%h exp 1/10/7f0", wr0_gnt, mem_addr, mem_wdata); end
        @(negedge clk); wr0_req = 1'b0; scan_req = 1'b1; scan_addr = 8'd10;
        @(negedge clk); scan_req = 1'b0; #1;
        checks++; if (scan_valid !== 1'b1 || scan_data !== 12'h7F0) begin failures++; $display("FAIL blk_readback valid=%b data=%h exp 1/7f0", scan_valid, scan_data); end
    endtask

    task automatic test_clear();
        int busy_cnt, done_cnt, early_gnt, scan_we;
        logic gnt_at_done;
        for (int i = 0; i < DEP; i++) begin
            @(negedge clk); wr0_req = 1'b1; wr0_addr = AW'(i); wr0_data = 12'hF00 | DW'(i);
        end
        @(negedge clk); wr0_req = 1'b0; #1;
        checks++; if (mem[3] !== 12'hF03 || mem[15] !== 12'hF0F) begin failures++; $display("FAIL clr_prefill got=%h/%h exp=f03/f0f", mem[3], mem[15]); end
        @(negedge clk); clear_start = 1'b1; #1;
        checks++; if (clear_busy !== 1'b0) begin failures++; $display("FAIL clr_start_busy got=%b exp=0", clear_busy); end
        busy_cnt = 0; done_cnt = 0; early_gnt = 0; scan_we = 0; gnt_at_done = 1'b0;
        wr1_addr = 8'd40; wr1_data = 12'h555;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            clear_start = (i == 5); wr1_req = 1'b1;
            scan_req = (i == 3 || i == 8); scan_addr = 8'd0;
            #1;
            if (clear_busy) busy_cnt++;
            if (scan_req && mem_we) scan_we++;
            if (clear_done) begin
                if (done_cnt == 0) gnt_at_done = wr1_gnt;
                done_cnt++;
            end else if (done_cnt == 0 && wr1_gnt) begin
                early_gnt++;
            end
        end
        @(negedge clk); idle_inputs(); #1;
        checks++; if (busy_cnt != DEP + 2) begin failures++; $display("FAIL clr_busy_cycles got=%0d exp=%0d", busy_cnt, DEP + 2); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL clr_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (early_gnt != 0) begin failures++; $display("FAIL clr_wr1_early got=%0d exp=0", early_gnt); end
        checks++; if (gnt_at_done !== 1'b1) begin failures++; $display("FAIL clr_wr1_at_done got=%b exp=1", gnt_at_done); end
        checks++; if (scan_we != 0) begin failures++; $display("FAIL clr_scan_we got=%0d exp=0", scan_we); end
        for (int a = 0; a < DEP; a++) begin
            checks++;
            if (mem[a] !== 12'h000) begin failures++; $display("FAIL clr_mem%0d got=%h exp=000", a, mem[a]); end
        end
        checks++; if (mem[40] !== 12'h555) begin failures++; $display("FAIL clr_wr1_mem got=%h exp=555", mem[40]); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        @(negedge clk); clear_start = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            wr0_req = 1'b1; wr0_addr = 8'd50; wr0_data = 12'h0A0;
            wr1_req = 1'b1; wr1_addr = 8'd51; wr1_data = 12'h0B0;
            scan_req = (i == 7); scan_addr = 8'd0;
            #1;
            if (clear_done) done_cnt++;
        end
        checks++; if ({clear_busy, scan_valid, mem_we} !== 3'b111 || mem_addr !== 8'd7) begin failures++; $display("FAIL rstmid_pre busy/sv/we=%b addr=%0d exp 111/7", {clear_busy, scan_valid, mem_we}, mem_addr); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({clear_busy, scan_valid, mem_we} !== 3'b000) begin failures++; $display("FAIL rstmid_async busy/sv/we=%b exp=000", {clear_busy, scan_valid, mem_we}); end
        checks++; if ({wr0_gnt, wr1_gnt} !== 2'b00) begin failures++; $display("FAIL rstmid_gnt got=%b exp=00", {wr0_gnt, wr1_gnt}); end
        repeat (2) begin
            @(negedge clk); #1;
            if (clear_done) done_cnt++;
        end
        @(negedge clk); reset = 1'b0; #1;
        if (clear_done) done_cnt++;
        checks++; if ({wr1_gnt, wr0_gnt} !== 2'b01) begin failures++; $display("FAIL rstmid_first_tie gnt=%b exp=01", {wr1_gnt, wr0_gnt}); end
        @(negedge clk); #1;
        if (clear_done) done_cnt++;
        checks++; if ({wr1_gnt, wr0_gnt} !== 2'b10 || clear_busy !== 1'b0) begin failures++; $display("FAIL rstmid_second gnt=%b busy=%b exp 10/0", {wr1_gnt, wr0_gnt}, clear_busy); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", done_cnt); end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        test_reset();
        test_scan();
        test_round_robin();
        test_scan_blocks_writer();
        test_clear();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
